ram_loader: RTL and testbench

- Program loader, the write-side counterpart of the SAP-1 fetch/execute path; the CPU only reads program RAM, this block fills it.
- Accepts a framed byte stream over a valid/ready interface, for example from a UART receiver.
- Holds the CPU while it writes RAM word by word through the RAM write port, checks a checksum, then releases the CPU with a restart pulse.
- Sits beside Top's RAM; its write port is muxed with the CPU's RAM write port while o_cpu_hold is high.

---
 rtl/ram_loader_if.sv | 33 +++
 rtl/ram_loader.sv | 146 ++++++++++++++
 tb/tb_ram_loader.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_loader_if.sv
// Stream-in and RAM-write signal bundle for the program loader.
// The loader takes the slave side; the byte source and the RAM take the master side.
interface ram_loader_if #(
  parameter int RAM_DEPTH = 16,
  parameter int RAM_WIDTH = 8
);
  localparam int ADDRESS_WIDTH = $clog2(RAM_DEPTH);

  logic                     i_rx_valid;
  logic [RAM_WIDTH-1:0]     i_rx_data;
  logic                     o_rx_ready;
  logic                     o_ram_we;
  logic [ADDRESS_WIDTH-1:0] o_ram_addr;
  logic [RAM_WIDTH-1:0]     o_ram_data;

  modport slave (
    input  i_rx_valid,
    input  i_rx_data,
    output o_rx_ready,
    output o_ram_we,
    output o_ram_addr,
    output o_ram_data
  );

  modport master (
    output i_rx_valid,
    output i_rx_data,
    input  o_rx_ready,
    input  o_ram_we,
    input  o_ram_addr,
    input  o_ram_data
  );
endinterface

// File: rtl/ram_loader.sv
// Program loader: receives a LEN/data/CSUM framed byte stream, writes it into the
// SAP-1 program RAM while holding the CPU, then releases it with a restart pulse.
module ram_loader #(
  parameter int RAM_DEPTH = 16,
  parameter int RAM_WIDTH = 8
) (
  input  logic          mclk,
  input  logic          rst_n,
  input  logic          i_mclk_en,
  input  logic          i_start,
  ram_loader_if.slave   bus,
  output logic          o_cpu_hold,
  output logic          o_cpu_restart,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);
  localparam int ADDRESS_WIDTH = $clog2(RAM_DEPTH);
  localparam logic [RAM_WIDTH:0] MAX_LEN = (RAM_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDRESS_WIDTH:0] REM_ONE = (ADDRESS_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH:0]   rem_q, rem_d;
  logic [RAM_WIDTH-1:0]     csum_q, csum_d;
  logic [RAM_WIDTH-1:0]     data_q, data_d;
  logic                     hold_q, hold_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;

  logic rxReady;
  logic accept;
  logic lenOk;

  assign rxReady = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign accept  = rxReady && bus.i_rx_valid;
  assign lenOk   = (bus.i_rx_data != '0) && ({1'b0, bus.i_rx_data} <= MAX_LEN);

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      csum_q  <= '0;
      data_q  <= '0;
      hold_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      csum_q  <= csum_d;
      data_q  <= data_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  // WRITE and DONE stall until an i_mclk_en edge so the CPU-clocked RAM and PC see them.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    csum_d  = csum_q;
    data_d  = data_q;
    hold_d  = hold_q;
    done_d  = done_q;
    error_d = error_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_LEN;
          hold_d  = 1'b1;
          done_d  = 1'b0;
          error_d = 1'b0;
          addr_d  = '0;
          csum_d  = '0;
        end
      end
      S_LEN: begin
        if (accept) begin
          if (lenOk) begin
            rem_d   = bus.i_rx_data[ADDRESS_WIDTH:0];
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          data_d  = bus.i_rx_data;
          csum_d  = csum_q + bus.i_rx_data;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (i_mclk_en) begin
          addr_d  = addr_q + 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == REM_ONE) ? S_CSUM : S_DATA;
        end
      end
      S_CSUM: begin
        if (accept) begin
          state_d = (bus.i_rx_data == csum_q) ? S_DONE : S_ERR;
        end
      end
      S_DONE: begin
        if (i_mclk_en) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end
      end
      S_ERR: begin
        error_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.o_rx_ready = rxReady;
  assign bus.o_ram_we   = (state_q == S_WRITE);
  assign bus.o_ram_addr = addr_q;
  assign bus.o_ram_data = data_q;
  assign o_cpu_restart  = (state_q == S_DONE);
  assign o_cpu_hold     = hold_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_done         = done_q;
  assign o_error        = error_q;
endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader: feeds framed byte streams and checks the RAM
// image, write/restart pulses and sticky status against hand-computed values.
module tb_ram_loader;
  logic mclk = 1'b0;
  logic rst_n;
  logic i_mclk_en;
  logic i_start;
  logic o_cpu_hold;
  logic o_cpu_restart;
  logic o_busy;
  logic o_done;
  logic o_error;

  ram_loader_if #(.RAM_DEPTH(16), .RAM_WIDTH(8)) bus ();

  ram_loader #(.RAM_DEPTH(16), .RAM_WIDTH(8)) dut (
    .mclk          (mclk),
    .rst_n         (rst_n),
    .i_mclk_en     (i_mclk_en),
    .i_start       (i_start),
    .bus           (bus),
    .o_cpu_hold    (o_cpu_hold),
    .o_cpu_restart (o_cpu_restart),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int passes = 0;
  int enMode = 1;
  int enCycle = 0;

  logic [7:0] ramModel [16];
  int writes, restartCycles, restartCommits, readyInWrite, stabErr;
  logic       prevWe = 1'b0, prevCommit = 1'b0;
  logic [3:0] prevAddr = '0;
  logic [7:0] prevData = '0;
  logic [7:0] frameQ [$];

  // enMode 0: never enabled, 1: always enabled, 2: enabled one cycle in four
  initial begin
    i_mclk_en = 1'b1;
    forever begin
      @(posedge mclk);
      #1;
      enCycle++;
      i_mclk_en = (enMode == 1) || (enMode == 2 && (enCycle % 4) == 0);
    end
  end

  // The RAM image is captured from committed writes: we high on an enabled edge.
  always @(negedge mclk) begin
    if (rst_n) begin
      if (bus.o_ram_we && i_mclk_en) begin
        ramModel[bus.o_ram_addr] = bus.o_ram_data;
        writes++;
      end
      if (bus.o_ram_we && bus.o_rx_ready) readyInWrite++;
      if (prevWe && !prevCommit && bus.o_ram_we &&
          (bus.o_ram_addr != prevAddr || bus.o_ram_data != prevData)) stabErr++;
      if (o_cpu_restart) restartCycles++;
      if (o_cpu_restart && i_mclk_en) restartCommits++;
    end
    prevWe     = bus.o_ram_we;
    prevCommit = bus.o_ram_we && i_mclk_en;
    prevAddr   = bus.o_ram_addr;
    prevData   = bus.o_ram_data;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    else
      passes++;
  endtask

  task automatic clearStats();
    writes = 0; restartCycles = 0; restartCommits = 0; readyInWrite = 0; stabErr = 0;
    for (int i = 0; i < 16; i++) ramModel[i] = 8'h00;
  endtask

  task automatic startLoad();
    i_start = 1'b1;
    @(posedge mclk); #1;
    i_start = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int waitCycles = 0;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    @(negedge mclk);
    while (!bus.o_rx_ready && waitCycles < 100) begin
      waitCycles++;
      @(negedge mclk);
    end
    if (!bus.o_rx_ready) checkOutput("rxTimeout", {31'b0, bus.o_rx_ready}, 1);
    @(posedge mclk); #1;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
  endtask

  task automatic waitIdle();
    int waitCycles = 0;
    @(negedge mclk);
    while (o_busy && waitCycles < 200) begin
      waitCycles++;
      @(negedge mclk);
    end
    checkOutput("idleReached", {31'b0, o_busy}, 0);
    @(posedge mclk); #1;
  endtask

  task automatic applyStimulus();
    clearStats();
    startLoad();
    foreach (frameQ[i]) sendByte(frameQ[i]);
    waitIdle();
  endtask

  task automatic checkStatus(input string tag, input logic done, input logic err, input logic hold);
    checkOutput({tag, ".done"},  {31'b0, o_done},     {31'b0, done});
    checkOutput({tag, ".error"}, {31'b0, o_error},    {31'b0, err});
    checkOutput({tag, ".hold"},  {31'b0, o_cpu_hold}, {31'b0, hold});
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'h00;
    clearStats();
    repeat (3) @(posedge mclk);
    #1;
    checkOutput("rst.ready",   {31'b0, bus.o_rx_ready}, 0);
    checkOutput("rst.we",      {31'b0, bus.o_ram_we},   0);
    checkOutput("rst.addr",    {28'b0, bus.o_ram_addr}, 0);
    checkOutput("rst.data",    {24'b0, bus.o_ram_data}, 0);
    checkOutput("rst.restart", {31'b0, o_cpu_restart},  0);
    checkOutput("rst.busy",    {31'b0, o_busy},         0);
    checkStatus("rst", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(posedge mclk); #1;

    // Basic load with the CPU clock enable tied high
    enMode = 1;
    frameQ = '{8'h03, 8'h1E, 8'h2F, 8'h10, 8'h5D};
    applyStimulus();
    checkOutput("s1.ram0", {24'b0, ramModel[0]}, 32'h1E);
    checkOutput("s1.ram1", {24'b0, ramModel[1]}, 32'h2F);
    checkOutput("s1.ram2", {24'b0, ramModel[2]}, 32'h10);
    checkOutput("s1.writes", writes, 3);
    checkOutput("s1.restartCycles", restartCycles, 1);
    checkOutput("s1.readyInWrite", readyInWrite, 0);
    checkStatus("s1", 1'b1, 1'b0, 1'b0);

    // Same frame with a sparse clock enable stretching WRITE and DONE
    enMode = 2;
    applyStimulus();
    checkOutput("s2.ram0", {24'b0, ramModel[0]}, 32'h1E);
    checkOutput("s2.ram1", {24'b0, ramModel[1]}, 32'h2F);
    checkOutput("s2.ram2", {24'b0, ramModel[2]}, 32'h10);
    checkOutput("s2.writes", writes, 3);
    checkOutput("s2.restartCommits", restartCommits, 1);
    checkOutput("s2.readyInWrite", readyInWrite, 0);
    checkOutput("s2.stable", stabErr, 0);
    checkStatus("s2", 1'b1, 1'b0, 1'b0);
    enMode = 1;

    // Illegal lengths, then recovery with a good load
    frameQ = '{8'h00};
    applyStimulus();
    checkOutput("s3a.writes", writes, 0);
    checkStatus("s3a", 1'b0, 1'b1, 1'b1);
    frameQ = '{8'h11};
    applyStimulus();
    checkOutput("s3b.writes", writes, 0);
    checkStatus("s3b", 1'b0, 1'b1, 1'b1);
    frameQ = '{8'h03, 8'h1E, 8'h2F, 8'h10, 8'h5D};
    applyStimulus();
    checkOutput("s3c.writes", writes, 3);
    checkStatus("s3c", 1'b1, 1'b0, 1'b0);

    // Full-depth frame: sum of 0..15 is 0x78, address wraps back to 0
    frameQ = '{8'h10};
    for (int i = 0; i < 16; i++) frameQ.push_back(8'(i));
    frameQ.push_back(8'h78);
    applyStimulus();
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("s4.ram%0d", i), {24'b0, ramModel[i]}, i);
    checkOutput("s4.writes", writes, 16);
    checkOutput("s4.addrWrap", {28'b0, bus.o_ram_addr}, 0);
    checkStatus("s4", 1'b1, 1'b0, 1'b0);

    // Bad checksum: FF+02 = 01, frame carries 00
    frameQ = '{8'h02, 8'hFF, 8'h02, 8'h00};
    applyStimulus();
    checkOutput("s5.ram0", {24'b0, ramModel[0]}, 32'hFF);
    checkOutput("s5.ram1", {24'b0, ramModel[1]}, 32'h02);
    checkOutput("s5.restartCycles", restartCycles, 0);
    checkStatus("s5", 1'b0, 1'b1, 1'b1);

    // i_start pulsed while in DATA is ignored
    clearStats();
    startLoad();
    sendByte(8'h02);
    i_start = 1'b1;
    @(posedge mclk); #1;
    i_start = 1'b0;
    sendByte(8'hA0);
    sendByte(8'h05);
    sendByte(8'hA5);
    waitIdle();
    checkOutput("s6.ram0", {24'b0, ramModel[0]}, 32'hA0);
    checkOutput("s6.ram1", {24'b0, ramModel[1]}, 32'h05);
    checkOutput("s6.writes", writes, 2);
    checkStatus("s6", 1'b1, 1'b0, 1'b0);

    // Reset while parked in WRITE drops we/hold/busy without a clock edge
    enMode = 0;
    @(posedge mclk); #1;
    clearStats();
    startLoad();
    sendByte(8'h03);
    sendByte(8'h1E);
    @(negedge mclk);
    checkOutput("s7.weBefore", {31'b0, bus.o_ram_we}, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("s7.we",   {31'b0, bus.o_ram_we}, 0);
    checkOutput("s7.hold", {31'b0, o_cpu_hold},   0);
    checkOutput("s7.busy", {31'b0, o_busy},       0);
    @(posedge mclk); #1;
    rst_n = 1'b1;
    enMode = 1;
    @(posedge mclk); #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
